// File: rtl/load_store_mem_port_pkg.sv
// Shared types and lane helpers for the load/store memory port.
// The misalign check (LDST_MISALIGN_CHECK_EN) uses is_misaligned() from here.
package ldst_port_pkg;

  typedef enum logic [1:0] {
    ORDER_BYTE = 2'b00,
    ORDER_HALF = 2'b01,
    ORDER_WORD = 2'b10,
    ORDER_NONE = 2'b11
  } order_e;

  typedef struct packed {
    order_e     order;
    logic [1:0] addr_lo;
    logic       rw;
    logic       fault;
  } pend_entry_t;

  // Big-endian lanes: byte 0 of a word lives in bits [31:24].
  function automatic logic [3:0] gen_byte_ena(order_e order, logic [1:0] addr_lo, logic [3:0] mask);
    logic [3:0] ena;
    case (order)
      ORDER_BYTE: ena = 4'b1000 >> addr_lo;
      ORDER_HALF: ena = addr_lo[1] ? 4'b0011 : 4'b1100;
      default:    ena = 4'b1111;
    endcase
    return ena & mask;
  endfunction

  function automatic logic [31:0] replicate_wdata(order_e order, logic [31:0] data);
    case (order)
      ORDER_BYTE: return {4{data[7:0]}};
      ORDER_HALF: return {2{data[15:0]}};
      default:    return data;
    endcase
  endfunction

  function automatic logic [31:0] extract_rdata(order_e order, logic [1:0] addr_lo, logic [31:0] data);
    logic [31:0] res;
    case (order)
      ORDER_BYTE: begin
        case (addr_lo)
          2'd0:    res = {24'h0, data[31:24]};
          2'd1:    res = {24'h0, data[23:16]};
          2'd2:    res = {24'h0, data[15:8]};
          default: res = {24'h0, data[7:0]};
        endcase
      end
      ORDER_HALF: res = addr_lo[1] ? {16'h0, data[15:0]} : {16'h0, data[31:16]};
      default:    res = data;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(order_e order, logic [1:0] addr_lo);
    return ((order == ORDER_HALF) && addr_lo[0]) || ((order == ORDER_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_mem_port_if.sv
// Arbiter-side LDST bus and memory-side bus of the load/store memory port.
interface ldst_bus_if;
  logic        iLDST_REQ;
  logic        oLDST_BUSY;
  logic [1:0]  iLDST_ORDER;
  logic [3:0]  iLDST_MASK;
  logic        iLDST_RW;
  logic [31:0] iLDST_ADDR;
  logic [31:0] iLDST_DATA;
  logic        oLDST_VALID;
  logic        oLDST_CACHE_HIT;
  logic [31:0] oLDST_DATA;
  logic        oLDST_FAULT;

  modport master (output iLDST_REQ, iLDST_ORDER, iLDST_MASK, iLDST_RW, iLDST_ADDR, iLDST_DATA,
                  input  oLDST_BUSY, oLDST_VALID, oLDST_CACHE_HIT, oLDST_DATA, oLDST_FAULT);
  modport slave  (input  iLDST_REQ, iLDST_ORDER, iLDST_MASK, iLDST_RW, iLDST_ADDR, iLDST_DATA,
                  output oLDST_BUSY, oLDST_VALID, oLDST_CACHE_HIT, oLDST_DATA, oLDST_FAULT);
endinterface

interface mem_bus_if;
  logic        oMEM_REQ;
  logic        iMEM_BUSY;
  logic        oMEM_RW;
  logic [31:0] oMEM_ADDR;
  logic [3:0]  oMEM_BYTE_ENA;
  logic [31:0] oMEM_DATA;
  logic        iMEM_VALID;
  logic        iMEM_CACHE_HIT;
  logic [31:0] iMEM_DATA;

  modport master (output oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_BYTE_ENA, oMEM_DATA,
                  input  iMEM_BUSY, iMEM_VALID, iMEM_CACHE_HIT, iMEM_DATA);
  modport slave  (input  oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_BYTE_ENA, oMEM_DATA,
                  output iMEM_BUSY, iMEM_VALID, iMEM_CACHE_HIT, iMEM_DATA);
endinterface

// File: rtl/load_store_mem_port_pending_fifo.sv
// In-order FIFO of requests issued to memory and awaiting their response.
module ldst_pending_fifo
  import ldst_port_pkg::*;
#(
  parameter int PENDING_DEPTH = 4,
  parameter int PENDING_AW    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  pend_entry_t         push_entry,
  input  logic                pop,
  output pend_entry_t         head,
  output logic                full,
  output logic                empty,
  output logic [PENDING_AW:0] count
);

  pend_entry_t           entries [PENDING_DEPTH];
  logic [PENDING_AW-1:0] wr_ptr_reg;
  logic [PENDING_AW-1:0] rd_ptr_reg;
  logic [PENDING_AW:0]   count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_reg == (PENDING_AW+1)'(PENDING_DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = entries[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr_reg] <= push_entry;
  end

  // Pointers are exactly PENDING_AW bits, so they wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/load_store_mem_port.sv
// Load/store memory port: lane formatting, one-entry issue register, in-order responses.
// Define LDST_MISALIGN_CHECK_EN to retire misaligned half/word accesses as faults.
module load_store_mem_port
  import ldst_port_pkg::*;
#(
  parameter int PENDING_DEPTH = 4,
  parameter int PENDING_AW    = 2
) (
  input  logic      iCLOCK,
  input  logic      inRESET,
  ldst_bus_if.slave ldst,
  mem_bus_if.master mem
);

  logic                  reg_valid;
  logic                  reg_fault;
  order_e                reg_order;
  logic [1:0]            reg_addr_lo;
  logic                  fault_busy_reg;
  logic                  accept, issue, pop, req_fault;
  logic                  fifo_full, fifo_empty;
  logic [PENDING_AW:0]   fifo_count;
  logic [PENDING_AW+1:0] occupancy;
  pend_entry_t           head, push_entry;
  order_e                req_order;

  assign req_order = order_e'(ldst.iLDST_ORDER);

`ifdef LDST_MISALIGN_CHECK_EN
  assign req_fault = is_misaligned(req_order, ldst.iLDST_ADDR[1:0]);
`else
  assign req_fault = 1'b0;
`endif

  assign occupancy = {1'b0, fifo_count} + {{(PENDING_AW+1){1'b0}}, reg_valid};
  // While a fault is in flight no new request is taken, so no memory response
  // can ever arrive while the faulted entry sits at the FIFO head.
  assign ldst.oLDST_BUSY = (mem.oMEM_REQ && mem.iMEM_BUSY)
                        || (occupancy >= (PENDING_AW+2)'(PENDING_DEPTH))
                        || fault_busy_reg;
  assign accept = ldst.iLDST_REQ && !ldst.oLDST_BUSY;
  assign issue  = reg_valid && (reg_fault || !mem.iMEM_BUSY);
  assign pop    = !fifo_empty && (head.fault || mem.iMEM_VALID);

  assign push_entry = '{order: reg_order, addr_lo: reg_addr_lo, rw: mem.oMEM_RW, fault: reg_fault};

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      reg_valid         <= 1'b0;
      reg_fault         <= 1'b0;
      reg_order         <= ORDER_BYTE;
      reg_addr_lo       <= 2'b00;
      mem.oMEM_REQ      <= 1'b0;
      mem.oMEM_RW       <= 1'b0;
      mem.oMEM_ADDR     <= '0;
      mem.oMEM_BYTE_ENA <= '0;
      mem.oMEM_DATA     <= '0;
    end else if (accept) begin
      reg_valid         <= 1'b1;
      reg_fault         <= req_fault;
      reg_order         <= req_order;
      reg_addr_lo       <= ldst.iLDST_ADDR[1:0];
      mem.oMEM_REQ      <= !req_fault;
      mem.oMEM_RW       <= ldst.iLDST_RW;
      mem.oMEM_ADDR     <= {ldst.iLDST_ADDR[31:2], 2'b00};
      mem.oMEM_BYTE_ENA <= gen_byte_ena(req_order, ldst.iLDST_ADDR[1:0], ldst.iLDST_MASK);
      mem.oMEM_DATA     <= replicate_wdata(req_order, ldst.iLDST_DATA);
    end else if (issue) begin
      reg_valid    <= 1'b0;
      mem.oMEM_REQ <= 1'b0;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      fault_busy_reg <= 1'b0;
    end else if (accept && req_fault) begin
      fault_busy_reg <= 1'b1;
    end else if (pop && head.fault) begin
      fault_busy_reg <= 1'b0;
    end
  end

  ldst_pending_fifo #(
    .PENDING_DEPTH(PENDING_DEPTH),
    .PENDING_AW   (PENDING_AW)
  ) u_pending (
    .clk       (iCLOCK),
    .rst_n     (inRESET),
    .push      (issue && !fifo_full),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ldst.oLDST_VALID     <= 1'b0;
      ldst.oLDST_CACHE_HIT <= 1'b0;
      ldst.oLDST_DATA      <= '0;
    end else if (pop) begin
      ldst.oLDST_VALID     <= 1'b1;
      ldst.oLDST_CACHE_HIT <= !head.fault && mem.iMEM_CACHE_HIT;
      ldst.oLDST_DATA      <= (head.fault || head.rw) ? 32'h0
                              : extract_rdata(head.order, head.addr_lo, mem.iMEM_DATA);
    end else begin
      ldst.oLDST_VALID <= 1'b0;
    end
  end

`ifdef LDST_MISALIGN_CHECK_EN
  logic rsp_fault_reg;
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)  rsp_fault_reg <= 1'b0;
    else if (pop)  rsp_fault_reg <= head.fault;
  end
  assign ldst.oLDST_FAULT = rsp_fault_reg;
`else
  assign ldst.oLDST_FAULT = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_mem_port.sv
// Randomized bench for load_store_mem_port with a queue-based reference model.
module tb_load_store_mem_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ldst_bus_if ldst();
  mem_bus_if  mem();

  load_store_mem_port #(.PENDING_DEPTH(4), .PENDING_AW(2)) dut (
    .iCLOCK (clk),
    .inRESET(rst_n),
    .ldst   (ldst),
    .mem    (mem)
  );

  typedef struct {
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        hit;
  } mrsp_t;

  req_t  rec_q[$];
  req_t  iss_q[$];
  int    due_q[$];
  mrsp_t resp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nrsp = 0;
  bit hold_rsp = 0, force_busy = 0, rand_busy = 0, fixed_lat = 1, fixed_data_en = 0;
  int stray = 0;
  logic [31:0] fixed_data = 32'h0;
  bit accepted;
  int acc_cyc = 0, mvalid_cyc = -1;
  bit rsp_seen;
  logic [31:0] last_rdata;
  logic last_fault;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_be(logic [1:0] o, logic [1:0] lo, logic [3:0] m);
    logic [3:0] g;
    case (o)
      2'd0:    g = 4'b1000 >> lo;
      2'd1:    g = lo[1] ? 4'b0011 : 4'b1100;
      default: g = 4'b1111;
    endcase
    return g & m;
  endfunction

  function automatic logic [31:0] exp_wdata(logic [1:0] o, logic [31:0] d);
    case (o)
      2'd0:    return (d & 32'hFF) * 32'h01010101;
      2'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_rdata(logic [1:0] o, logic [1:0] lo, logic [31:0] d);
    case (o)
      2'd0:    return (d >> (8 * (3 - int'(lo)))) & 32'hFF;
      2'd1:    return lo[1] ? (d & 32'hFFFF) : (d >> 16);
      default: return d;
    endcase
  endfunction

  function automatic logic exp_fault(logic [1:0] o, logic [1:0] lo);
`ifdef LDST_MISALIGN_CHECK_EN
    return (o == 2'd1 && lo[0]) || (o == 2'd2 && lo != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive memory, observe issue/accept, cross the edge, check responses.
  task automatic step();
    req_t r;
    mrsp_t m;
    logic [31:0] ed;
    logic eh, ef;
    mem.iMEM_BUSY      = force_busy || (rand_busy && $urandom_range(0, 3) == 0);
    mem.iMEM_VALID     = 1'b0;
    mem.iMEM_DATA      = $urandom;
    mem.iMEM_CACHE_HIT = 1'($urandom_range(0, 1));
    if (stray > 0) begin
      stray--;
      mem.iMEM_VALID = 1'b1;
    end else if (!hold_rsp && due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      if (fixed_data_en) mem.iMEM_DATA = fixed_data;
      mem.iMEM_VALID = 1'b1;
      m.data = mem.iMEM_DATA;
      m.hit  = mem.iMEM_CACHE_HIT;
      resp_q.push_back(m);
      if (mvalid_cyc < 0) mvalid_cyc = cyc;
    end
    #1;
    accepted = 1'b0;
    if (mem.oMEM_REQ && !mem.iMEM_BUSY) begin
      if (iss_q.size() == 0) check("spurious_issue", 32'd1, 32'd0);
      else begin
        r = iss_q.pop_front();
        check("mem_addr", mem.oMEM_ADDR, {r.addr[31:2], 2'b00});
        check("mem_be", 32'(mem.oMEM_BYTE_ENA), 32'(exp_be(r.order, r.addr[1:0], r.mask)));
        check("mem_rw", 32'(mem.oMEM_RW), 32'(r.rw));
        if (r.rw) check("mem_wdata", mem.oMEM_DATA, exp_wdata(r.order, r.data));
        due_q.push_back(cyc + 1 + (fixed_lat ? 0 : int'($urandom_range(0, 3))));
      end
    end
    if (ldst.iLDST_REQ && !ldst.oLDST_BUSY) begin
      accepted = 1'b1;
      acc_cyc  = cyc;
      r.order = ldst.iLDST_ORDER;
      r.mask  = ldst.iLDST_MASK;
      r.rw    = ldst.iLDST_RW;
      r.addr  = ldst.iLDST_ADDR;
      r.data  = ldst.iLDST_DATA;
      r.fault = exp_fault(r.order, r.addr[1:0]);
      rec_q.push_back(r);
      if (!r.fault) iss_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    rsp_seen = 1'b0;
    if (ldst.oLDST_VALID) begin
      rsp_seen   = 1'b1;
      last_rdata = ldst.oLDST_DATA;
      last_fault = ldst.oLDST_FAULT;
      if (rec_q.size() == 0) check("spurious_rsp", 32'd1, 32'd0);
      else begin
        r = rec_q.pop_front();
        ed = 32'h0; eh = 1'b0; ef = 1'b0;
        if (r.fault) ef = 1'b1;
        else if (resp_q.size() == 0) check("rsp_without_mem", 32'd1, 32'd0);
        else begin
          m  = resp_q.pop_front();
          ed = r.rw ? 32'h0 : exp_rdata(r.order, r.addr[1:0], m.data);
          eh = m.hit;
        end
        check("rsp_data", ldst.oLDST_DATA, ed);
        check("rsp_hit", 32'(ldst.oLDST_CACHE_HIT), 32'(eh));
        check("rsp_fault", 32'(ldst.oLDST_FAULT), 32'(ef));
        nrsp++;
        $display("rsp %0d: addr=%08h order=%0d rw=%0d data=%08h hit=%0b fault=%0b",
                 nrsp, r.addr, r.order, r.rw, ldst.oLDST_DATA, ldst.oLDST_CACHE_HIT, ldst.oLDST_FAULT);
      end
    end
  endtask

  task automatic send(logic [1:0] o, logic [3:0] m, logic rw, logic [31:0] a, logic [31:0] d);
    ldst.iLDST_REQ   = 1'b1;
    ldst.iLDST_ORDER = o;
    ldst.iLDST_MASK  = m;
    ldst.iLDST_RW    = rw;
    ldst.iLDST_ADDR  = a;
    ldst.iLDST_DATA  = d;
    for (int i = 0; i < 60; i++) begin
      step();
      if (accepted) break;
    end
    ldst.iLDST_REQ = 1'b0;
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && rec_q.size() > 0; i++) step();
    check("drain_pending", 32'(rec_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_mem_req"}, 32'(mem.oMEM_REQ), 32'd0);
    check({tag, "_busy"}, 32'(ldst.oLDST_BUSY), 32'd0);
    check({tag, "_valid"}, 32'(ldst.oLDST_VALID), 32'd0);
    check({tag, "_rdata"}, ldst.oLDST_DATA, 32'd0);
    check({tag, "_fault"}, 32'(ldst.oLDST_FAULT), 32'd0);
    check({tag, "_hit"}, 32'(ldst.oLDST_CACHE_HIT), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ldst.iLDST_REQ = 1'b0;
    mem.iMEM_VALID = 1'b0;
    mem.iMEM_BUSY  = 1'b0;
    rec_q.delete(); iss_q.delete(); due_q.delete(); resp_q.delete();
    #1;
    check_idle_outputs("rst");
    check("rst_mem_addr", mem.oMEM_ADDR, 32'd0);
    check("rst_mem_be", 32'(mem.oMEM_BYTE_ENA), 32'd0);
    check("rst_mem_wdata", mem.oMEM_DATA, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int acc_any;
    int t_start;
    ldst.iLDST_REQ = 0; ldst.iLDST_ORDER = 0; ldst.iLDST_MASK = 4'hF;
    ldst.iLDST_RW = 0; ldst.iLDST_ADDR = 0; ldst.iLDST_DATA = 0;
    mem.iMEM_BUSY = 0; mem.iMEM_VALID = 0; mem.iMEM_CACHE_HIT = 0; mem.iMEM_DATA = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Byte read at 0x1003 with single-cycle memory
    fixed_data_en = 1; fixed_data = 32'hAABBCCDD;
    send(2'd0, 4'hF, 1'b0, 32'h0000_1003, 32'h0);
    check("byte_req", 32'(mem.oMEM_REQ), 32'd1);
    check("byte_be", 32'(mem.oMEM_BYTE_ENA), 32'b0001);
    check("byte_addr", mem.oMEM_ADDR, 32'h0000_1000);
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_seen) break;
    end
    check("byte_latency", 32'(cyc - acc_cyc), 32'd3);
    check("byte_rdata", last_rdata, 32'h0000_00DD);
    fixed_data_en = 0;

    // Halfword write replication and masked word write
    send(2'd1, 4'hF, 1'b1, 32'h0000_2002, 32'h0000_1234);
    check("half_wdata", mem.oMEM_DATA, 32'h1234_1234);
    check("half_be", 32'(mem.oMEM_BYTE_ENA), 32'b0011);
    send(2'd2, 4'b1010, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF);
    check("mask_be", 32'(mem.oMEM_BYTE_ENA), 32'b1010);
    drain();

    // Fill the pending FIFO with responses withheld
    hold_rsp = 1;
    for (int i = 0; i < 4; i++) send(2'd2, 4'hF, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
    step();
    check("full_busy", 32'(ldst.oLDST_BUSY), 32'd1);
    ldst.iLDST_REQ = 1; ldst.iLDST_ORDER = 2'd0; ldst.iLDST_MASK = 4'hF;
    ldst.iLDST_RW = 0; ldst.iLDST_ADDR = 32'h0000_0201;
    acc_any = 0;
    repeat (3) begin
      step();
      if (accepted) acc_any++;
    end
    check("fifth_stalled", 32'(acc_any), 32'd0);
    mvalid_cyc = -1;
    hold_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (accepted) break;
    end
    ldst.iLDST_REQ = 0;
    check("fifth_accept_cycle", 32'(acc_cyc), 32'(mvalid_cyc + 1));
    drain();

    // Memory stalls the output register for 3 cycles
    force_busy = 1;
    send(2'd2, 4'hF, 1'b1, 32'h0000_5000, 32'hCAFE_F00D);
    repeat (3) begin
      step();
      check("stall_req", 32'(mem.oMEM_REQ), 32'd1);
      check("stall_busy", 32'(ldst.oLDST_BUSY), 32'd1);
      check("stall_addr", mem.oMEM_ADDR, 32'h0000_5000);
      check("stall_be", 32'(mem.oMEM_BYTE_ENA), 32'hF);
      check("stall_wdata", mem.oMEM_DATA, 32'hCAFE_F00D);
    end
    force_busy = 0;
    drain();

    // Reset with two outstanding reads, then stray memory responses
    hold_rsp = 1;
    send(2'd2, 4'hF, 1'b0, 32'h0000_6000, 32'h0);
    send(2'd1, 4'hF, 1'b0, 32'h0000_6002, 32'h0);
    repeat (2) step();
    do_reset();
    hold_rsp = 0;
    stray = 2;
    repeat (4) begin
      step();
      check("stray_no_valid", 32'(ldst.oLDST_VALID), 32'd0);
    end
    check_idle_outputs("post_stray");

`ifdef LDST_MISALIGN_CHECK_EN
    // Misaligned word read behind a pending read
    hold_rsp = 1;
    send(2'd2, 4'hF, 1'b0, 32'h0000_4000, 32'h0);
    send(2'd2, 4'hF, 1'b0, 32'h0000_3001, 32'h0);
    check("fault_no_req", 32'(mem.oMEM_REQ), 32'd0);
    repeat (3) step();
    hold_rsp = 0;
    drain();
    check("fault_last", 32'(last_fault), 32'd1);
`endif

    // Randomized traffic with random memory stalls and latency
    rand_busy = 1; fixed_lat = 0;
    t_start = nrsp;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom),
           1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    drain();
    check("random_rsp_count", 32'(nrsp - t_start), 32'd300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
